alu_flag_register: RTL and testbench

Holds the Z80 F register and its shadow F', fed directly by the 8-bit ALU status_flag output (layout S Z Y H X P/V N C, bit7..bit0). Applies per-instruction flag write masks and merges two 8-bit ALU passes into one 16-bit flag result (ADC/SBC HL,ss). Sources the carry for the next ALU pass and evaluates the Z80 condition codes for jump/call/ret control.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_flag_register_cond_eval.sv | 29 ++
 rtl/alu_flag_register.sv | 128 ++++++++++++
 tb/tb_alu_flag_register.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, condition codes, flag masks, flag FSM states.
// Pure declarations, so there is no latency and no backpressure.
package alu_pkg;

    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_Y  = 5;
    localparam int FLAG_H  = 4;
    localparam int FLAG_X  = 3;
    localparam int FLAG_PV = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 0;

    localparam logic [7:0] MASK_ALL    = 8'hFF;
    localparam logic [7:0] MASK_ADD16  = 8'b0011_1011;
    localparam logic [7:0] MASK_INCDEC = 8'hFE;

    typedef enum logic [2:0] {NZ, Z, NC, C, PO, PE, P, M} cond_code_t;

    typedef enum logic {ST_IDLE, ST_WAIT_HI} flag_state_t;

endpackage

// File: rtl/alu_flag_register_cond_eval.sv
// Z80 condition-code decode against the active flags.
// Combinational with zero latency; there is no backpressure.
module alu_flag_register_cond_eval
    import alu_pkg::*;
(
    input  logic       i_s,
    input  logic       i_z,
    input  logic       i_pv,
    input  logic       i_c,
    input  logic [2:0] i_cc,
    output logic       o_true
);

    always_comb begin
        o_true = 1'b0;
        case (cond_code_t'(i_cc))
            NZ: o_true = ~i_z;
            Z:  o_true = i_z;
            NC: o_true = ~i_c;
            C:  o_true = i_c;
            PO: o_true = ~i_pv;
            PE: o_true = i_pv;
            P:  o_true = ~i_s;
            M:  o_true = i_s;
            default: o_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_register.sv
// Z80 F/F' register with masked ALU updates and two-pass 16-bit flag merge.
// Latency 1 clk from alu_valid to flags; there is no backpressure, so every alu_valid is consumed.
module alu_flag_register
    import alu_pkg::*;
#(
    parameter int                    flag_width  = 8,
    parameter logic [flag_width-1:0] reset_flags = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [flag_width-1:0] alu_status,
    input  logic                  alu_valid,
    input  logic [flag_width-1:0] flag_mask,
    input  logic                  wide,
    input  logic                  wide_hi,
    input  logic                  ex_af,
    input  logic                  f_load,
    input  logic [flag_width-1:0] f_load_data,
    input  logic [2:0]            cond_code,
    output logic [flag_width-1:0] flags,
    output logic                  carry_in,
    output logic                  cond_true,
    output logic                  wide_pending,
    output logic                  seq_error
);

    logic [flag_width-1:0] r_f0;
    logic [flag_width-1:0] r_f1;
    logic                  r_bank;
    flag_state_t           r_state;
    logic                  r_lo_z;
    logic                  r_lo_c;
    logic                  r_seq_error;

    logic [flag_width-1:0] w_active;
    logic [flag_width-1:0] w_alu_dat;
    logic [flag_width-1:0] w_active_nxt;
    logic                  w_alu_wr;
    logic                  w_err_set;
    flag_state_t           w_state_nxt;
    logic                  w_lo_z_nxt;
    logic                  w_lo_c_nxt;

    assign w_active = r_bank ? r_f1 : r_f0;

    always_comb begin
        w_alu_wr    = 1'b0;
        w_alu_dat   = alu_status;
        w_err_set   = 1'b0;
        w_state_nxt = r_state;
        w_lo_z_nxt  = r_lo_z;
        w_lo_c_nxt  = r_lo_c;
        if (alu_valid) begin
            if (r_state == ST_WAIT_HI && wide && wide_hi) begin
                // The 16-bit result is zero only if both byte passes were zero
                w_alu_wr          = 1'b1;
                w_alu_dat[FLAG_Z] = alu_status[FLAG_Z] & r_lo_z;
                w_state_nxt       = ST_IDLE;
                w_lo_z_nxt        = 1'b0;
                w_lo_c_nxt        = 1'b0;
            end else begin
                if (r_state == ST_WAIT_HI) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_lo_z_nxt  = 1'b0;
                    w_lo_c_nxt  = 1'b0;
                end
                if (!wide) begin
                    w_alu_wr = 1'b1;
                end else if (!wide_hi) begin
                    w_lo_z_nxt  = alu_status[FLAG_Z];
                    w_lo_c_nxt  = alu_status[FLAG_C];
                    w_state_nxt = ST_WAIT_HI;
                end else begin
                    w_err_set = 1'b1;
                end
            end
        end
    end

    // f_load wins over an ALU write landing on the same (pre-swap) bank
    always_comb begin
        w_active_nxt = w_active;
        if (f_load) begin
            w_active_nxt = f_load_data;
        end else if (w_alu_wr) begin
            w_active_nxt = (w_alu_dat & flag_mask) | (w_active & ~flag_mask);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_f0        <= reset_flags;
            r_f1        <= reset_flags;
            r_bank      <= 1'b0;
            r_state     <= ST_IDLE;
            r_lo_z      <= 1'b0;
            r_lo_c      <= 1'b0;
            r_seq_error <= 1'b0;
        end else begin
            if (r_bank) begin
                r_f1 <= w_active_nxt;
            end else begin
                r_f0 <= w_active_nxt;
            end
            r_bank      <= r_bank ^ ex_af;
            r_state     <= w_state_nxt;
            r_lo_z      <= w_lo_z_nxt;
            r_lo_c      <= w_lo_c_nxt;
            r_seq_error <= r_seq_error | w_err_set;
        end
    end

    assign flags        = w_active;
    assign wide_pending = (r_state == ST_WAIT_HI);
    assign carry_in     = (r_state == ST_WAIT_HI) ? r_lo_c : w_active[FLAG_C];
    assign seq_error    = r_seq_error;

    alu_flag_register_cond_eval u_cond_eval (
        .i_s    (w_active[FLAG_S]),
        .i_z    (w_active[FLAG_Z]),
        .i_pv   (w_active[FLAG_PV]),
        .i_c    (w_active[FLAG_C]),
        .i_cc   (cond_code),
        .o_true (cond_true)
    );

endmodule

// File: tb/tb_alu_flag_register.sv
// Directed scoreboard bench for alu_flag_register.
module tb_alu_flag_register;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] alu_status;
    logic       alu_valid;
    logic [7:0] flag_mask;
    logic       wide;
    logic       wide_hi;
    logic       ex_af;
    logic       f_load;
    logic [7:0] f_load_data;
    logic [2:0] cond_code;
    logic [7:0] flags;
    logic       carry_in;
    logic       cond_true;
    logic       wide_pending;
    logic       seq_error;

    typedef struct {
        string      tag;
        logic [7:0] f;
        logic       c;
        logic       p;
        logic       e;
        logic       t;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    alu_flag_register #(.flag_width(8), .reset_flags(8'hFF)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alu_status   (alu_status),
        .alu_valid    (alu_valid),
        .flag_mask    (flag_mask),
        .wide         (wide),
        .wide_hi      (wide_hi),
        .ex_af        (ex_af),
        .f_load       (f_load),
        .f_load_data  (f_load_data),
        .cond_code    (cond_code),
        .flags        (flags),
        .carry_in     (carry_in),
        .cond_true    (cond_true),
        .wide_pending (wide_pending),
        .seq_error    (seq_error)
    );

    always #5 clk = ~clk;

    task automatic expect_st(input string tag, input logic [7:0] f, input logic c,
                             input logic p, input logic e, input logic t);
        exp_t x;
        x.tag = tag; x.f = f; x.c = c; x.p = p; x.e = e; x.t = t;
        q.push_back(x);
    endtask

    task automatic check_pop();
        exp_t x;
        if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        x = q.pop_front();
        n_cmp++;
        assert (flags === x.f) else begin
            n_fail++; $error("FAIL %s.flags observed=%h expected=%h", x.tag, flags, x.f);
        end
        n_cmp++;
        assert (carry_in === x.c) else begin
            n_fail++; $error("FAIL %s.carry_in observed=%b expected=%b", x.tag, carry_in, x.c);
        end
        n_cmp++;
        assert (wide_pending === x.p) else begin
            n_fail++; $error("FAIL %s.wide_pending observed=%b expected=%b", x.tag, wide_pending, x.p);
        end
        n_cmp++;
        assert (seq_error === x.e) else begin
            n_fail++; $error("FAIL %s.seq_error observed=%b expected=%b", x.tag, seq_error, x.e);
        end
        n_cmp++;
        assert (cond_true === x.t) else begin
            n_fail++; $error("FAIL %s.cond_true observed=%b expected=%b", x.tag, cond_true, x.t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        wide      = 1'b0;
        wide_hi   = 1'b0;
        ex_af     = 1'b0;
        f_load    = 1'b0;
        check_pop();
    endtask

    task automatic alu(input logic [7:0] st, input logic [7:0] mk, input logic w, input logic h);
        alu_valid = 1'b1; alu_status = st; flag_mask = mk; wide = w; wide_hi = h;
    endtask

    initial begin
        reset_n = 1'b0; alu_status = 8'h00; alu_valid = 1'b0; flag_mask = 8'h00;
        wide = 1'b0; wide_hi = 1'b0; ex_af = 1'b0; f_load = 1'b0; f_load_data = 8'h00;
        cond_code = 3'd1;
        #12;
        expect_st("reset", 8'hFF, 1, 0, 0, 1); check_pop();
        reset_n = 1'b1;

        cond_code = 3'd2;
        expect_st("idle_nc", 8'hFF, 1, 0, 0, 0); step();

        cond_code = 3'd1; alu(8'h51, 8'hFF, 0, 0);
        expect_st("add_narrow", 8'h51, 1, 0, 0, 1); step();

        cond_code = 3'd3; alu(8'h00, 8'hFE, 0, 0);
        expect_st("mask_fe", 8'h01, 1, 0, 0, 1); step();

        cond_code = 3'd1; alu(8'h42, 8'hFF, 1, 0);
        expect_st("sbc_lo1", 8'h01, 0, 1, 0, 0); step();
        alu(8'h42, 8'hFF, 1, 1);
        expect_st("sbc_hi1", 8'h42, 0, 0, 0, 1); step();

        alu(8'h02, 8'hFF, 1, 0);
        expect_st("sbc_lo2", 8'h42, 0, 1, 0, 1); step();
        cond_code = 3'd0; alu(8'h42, 8'hFF, 1, 1);
        expect_st("sbc_hi2", 8'h02, 0, 0, 0, 1); step();

        cond_code = 3'd4; alu(8'h51, 8'hFF, 0, 0);
        expect_st("set_51", 8'h51, 1, 0, 0, 1); step();

        cond_code = 3'd5; ex_af = 1'b1;
        expect_st("exaf_1", 8'hFF, 1, 0, 0, 1); step();

        cond_code = 3'd7; f_load = 1'b1; f_load_data = 8'h10;
        expect_st("fload_10", 8'h10, 0, 0, 0, 0); step();

        cond_code = 3'd6; ex_af = 1'b1;
        expect_st("exaf_2", 8'h51, 1, 0, 0, 1); step();

        cond_code = 3'd7; alu(8'h00, 8'hFF, 0, 0); f_load = 1'b1; f_load_data = 8'hA5;
        expect_st("pop_wins", 8'hA5, 1, 0, 0, 1); step();

        cond_code = 3'd3; alu(8'h3C, 8'hFF, 0, 0); ex_af = 1'b1;
        expect_st("alu_exaf", 8'h10, 0, 0, 0, 0); step();
        ex_af = 1'b1;
        expect_st("shadow_chk", 8'h3C, 0, 0, 0, 0); step();

        alu(8'h00, 8'hFF, 1, 1);
        expect_st("hi_from_idle", 8'h3C, 0, 0, 1, 0); step();

        alu(8'h01, 8'hFF, 1, 0);
        expect_st("lo_after_err", 8'h3C, 1, 1, 1, 0); step();

        f_load = 1'b1; f_load_data = 8'h77;
        expect_st("fload_wait", 8'h77, 1, 1, 1, 1); step();

        #2 reset_n = 1'b0;
        #2;
        expect_st("reset_mid", 8'hFF, 1, 0, 0, 1); check_pop();
        #2 reset_n = 1'b1;

        alu(8'h40, 8'hFF, 1, 0);
        expect_st("lo_again", 8'hFF, 0, 1, 0, 1); step();

        cond_code = 3'd7; alu(8'h80, 8'hFF, 0, 0);
        expect_st("narrow_in_wait", 8'h80, 0, 0, 1, 1); step();

        alu(8'h7F, 8'h00, 0, 0);
        expect_st("mask_00", 8'h80, 0, 0, 1, 1); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
